// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer, the stall controller and E-stage decode.
// Op and state encodings, default latencies and small op-class helpers.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MUL_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF = 10;

  // MULT..DIVU occupy the low half of the encoding space
  function automatic logic md_is_arith(input logic [2:0] op);
    return !op[2];
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return !op[2] && op[1];
  endfunction

endpackage

// File: rtl/md_if.sv
// Bus between the E stage / hazard controller and the multiply/divide sequencer.
interface md_if;

  logic        start;
  logic [2:0]  mdop;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        busy;
  logic [31:0] out;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] busy_cnt;

  modport master (
    output start, mdop, src1, src2, flush,
    input  busy, out, hi, lo, busy_cnt
  );

  modport slave (
    input  start, mdop, src1, src2, flush,
    output busy, out, hi, lo, busy_cnt
  );

endinterface

// File: rtl/md_arith.sv
// Purely combinational 32x32 multiply and divide for MULT/MULTU/DIV/DIVU.
// Division results are truncated toward zero; the remainder follows the dividend's sign.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        divzero
);

  logic signed [63:0] a_s;
  logic signed [63:0] b_s;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        b_zero;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] sdiv;
  logic [31:0] udiv;
  logic [31:0] mag_q;
  logic [31:0] mag_r;
  logic [31:0] u_q;
  logic [31:0] u_r;

  assign a_s    = {{32{a[31]}}, a};
  assign b_s    = {{32{b[31]}}, b};
  assign prod_s = a_s * b_s;
  assign prod_u = {32'h0, a} * {32'h0, b};

  // Signed divide works on magnitudes so the most-negative dividend needs no special case
  assign b_zero = (b == 32'h0);
  assign mag_a  = a[31] ? (32'h0 - a) : a;
  assign mag_b  = b[31] ? (32'h0 - b) : b;
  assign sdiv   = b_zero ? 32'd1 : mag_b;
  assign udiv   = b_zero ? 32'd1 : b;
  assign mag_q  = mag_a / sdiv;
  assign mag_r  = mag_a % sdiv;
  assign u_q    = a / udiv;
  assign u_r    = a % udiv;

  always_comb begin
    res_hi  = 32'h0;
    res_lo  = 32'h0;
    divzero = 1'b0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        divzero = b_zero;
        res_lo  = (a[31] ^ b[31]) ? (32'h0 - mag_q) : mag_q;
        res_hi  = a[31] ? (32'h0 - mag_r) : mag_r;
      end
      MD_DIVU: begin
        divzero = b_zero;
        res_lo  = u_q;
        res_hi  = u_r;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer: fixed-latency busy window, HI/LO ownership, flush abort.
// Optional busy-cycle counter enabled by defining MD_BUSY_CNT_EN.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MUL_LAT = MD_MUL_LAT_DEF,
  parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);

  md_state_e   state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] hi_q, hi_nx;
  logic [31:0] lo_q, lo_nx;
  logic [31:0] pend_hi, pend_hi_nx;
  logic [31:0] pend_lo, pend_lo_nx;
  logic        pend_ok, pend_ok_nx;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        divzero;

  md_arith u_arith (
    .op      (bus.mdop),
    .a       (bus.src1),
    .b       (bus.src2),
    .res_hi  (res_hi),
    .res_lo  (res_lo),
    .divzero (divzero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= MD_IDLE;
      cnt     <= 4'd0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      pend_hi <= 32'h0;
      pend_lo <= 32'h0;
      pend_ok <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      hi_q    <= hi_nx;
      lo_q    <= lo_nx;
      pend_hi <= pend_hi_nx;
      pend_lo <= pend_lo_nx;
      pend_ok <= pend_ok_nx;
    end
  end

  // Flush always wins: it blocks launches, MTHI/MTLO writes and the final commit
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    hi_nx      = hi_q;
    lo_nx      = lo_q;
    pend_hi_nx = pend_hi;
    pend_lo_nx = pend_lo;
    pend_ok_nx = pend_ok;
    case (state)
      MD_IDLE: begin
        if (bus.start && !bus.flush) begin
          if (md_is_arith(bus.mdop)) begin
            state_nx   = MD_RUN;
            cnt_nx     = md_is_div(bus.mdop) ? 4'(DIV_LAT) : 4'(MUL_LAT);
            pend_hi_nx = res_hi;
            pend_lo_nx = res_lo;
            pend_ok_nx = !divzero;
          end else if (bus.mdop == MD_MTHI) begin
            hi_nx = bus.src1;
          end else if (bus.mdop == MD_MTLO) begin
            lo_nx = bus.src1;
          end
        end
      end
      MD_RUN: begin
        if (bus.flush) begin
          state_nx = MD_IDLE;
          cnt_nx   = 4'd0;
        end else if (cnt == 4'd1) begin
          state_nx = MD_IDLE;
          cnt_nx   = 4'd0;
          if (pend_ok) begin
            hi_nx = pend_hi;
            lo_nx = pend_lo;
          end
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: state_nx = MD_IDLE;
    endcase
  end

  assign bus.busy = (state == MD_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.out  = (bus.mdop == MD_MFHI) ? hi_q : lo_q;

`ifdef MD_BUSY_CNT_EN
  logic [31:0] busy_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cnt_q <= 32'h0;
    end else if (state == MD_RUN) begin
      busy_cnt_q <= busy_cnt_q + 32'd1;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;
`else
  assign bus.busy_cnt = 32'h0;
`endif

endmodule
